// File: rtl/switch_conditioner_pkg.sv
// Shared constants for the switch conditioner.
//   mode_e                  : output selection shared by all channels
//   DEFAULT_N               : default channel count
//   DEFAULT_DEBOUNCE_CYCLES : default number of stable cycles before acceptance
//   cnt_width()             : width of the per-channel debounce counter
package switch_conditioner_pkg;

  typedef enum logic {
    MODE_LEVEL  = 1'b0,
    MODE_TOGGLE = 1'b1
  } mode_e;

  localparam int DEFAULT_N               = 4;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 4;

  // The counter must hold 0 .. cycles-1. Sizing for cycles+1 values keeps
  // the width at least one bit when cycles == 1.
  function automatic int cnt_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/switch_debounce_ch.sv
// One switch channel: two-flop synchroniser, polarity, debounce counter,
// debounced level, toggle state and registered edge pulses.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   x        : raw asynchronous switch level
//   d        : debounced (polarity-corrected) level
//   t        : toggle state, flips once per accepted rising edge of d
//   rise     : one-cycle pulse after d goes 0->1
//   fall     : one-cycle pulse after d goes 1->0
module switch_debounce_ch
  import switch_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter bit INVERT          = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic x,
  output logic d,
  output logic t,
  output logic rise,
  output logic fall
);

  localparam int               CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_q;
  logic             s;
  logic             p;
  logic [CNT_W-1:0] cnt;

  // Polarity is applied after synchronisation so the flops only ever see
  // the raw pin.
  assign p = s ^ INVERT;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 1'b0;
      s      <= 1'b0;
    end else begin
      sync_q <= x;
      s      <= sync_q;
    end
  end

  // Counter only advances while p disagrees with d; reaching CNT_LAST with a
  // mismatch is the update edge, which also clears the counter, so the
  // counter has no path past CNT_LAST.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      d    <= INVERT;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (p == d) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        d    <= p;
        cnt  <= '0;
        rise <= p;
        fall <= ~p;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Toggle follows the registered rise pulse, so it changes one edge after d.
  always_ff @(posedge clk) begin
    if (rst) begin
      t <= 1'b0;
    end else if (rise) begin
      t <= ~t;
    end
  end

endmodule

// File: rtl/switch_conditioner.sv
// N-channel switch conditioner: each channel is synchronised, polarity
// corrected and debounced independently; f shows either the debounced level
// or a per-channel toggle state depending on mode.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   x[N]     : raw asynchronous switch levels
//   mode     : 0 = level (f = d), 1 = toggle (f = t), shared by all channels
//   f[N]     : conditioned output
//   rise[N]  : one-cycle pulse after a channel's debounced level goes 0->1
//   fall[N]  : one-cycle pulse after a channel's debounced level goes 1->0
module switch_conditioner
  import switch_conditioner_pkg::*;
#(
  parameter int           N               = DEFAULT_N,
  parameter int           DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter logic [N-1:0] INVERT_MASK     = {N{1'b1}}
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] x,
  input  logic         mode,
  output logic [N-1:0] f,
  output logic [N-1:0] rise,
  output logic [N-1:0] fall
);

  logic [N-1:0] d;
  logic [N-1:0] t;

  for (genvar i = 0; i < N; i++) begin : g_ch
    switch_debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .INVERT          (INVERT_MASK[i])
    ) u_ch (
      .clk  (clk),
      .rst  (rst),
      .x    (x[i]),
      .d    (d[i]),
      .t    (t[i]),
      .rise (rise[i]),
      .fall (fall[i])
    );
  end

  // Both mux inputs are flop outputs, so f carries no combinational hazards
  // from the raw inputs; mode switches f immediately without touching state.
  always_comb begin
    f = (mode_e'(mode) == MODE_TOGGLE) ? t : d;
  end

endmodule

// File: tb/tb_switch_conditioner.sv
module tb_switch_conditioner;

  localparam int           N    = 4;
  localparam int           DC   = 4;
  localparam logic [N-1:0] MASK = 4'b0101;

  logic         clk;
  logic         rst;
  logic [N-1:0] x;
  logic         mode;
  logic [N-1:0] f;
  logic [N-1:0] rise;
  logic [N-1:0] fall;

  switch_conditioner #(
    .N               (N),
    .DEBOUNCE_CYCLES (DC),
    .INVERT_MASK     (MASK)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .x    (x),
    .mode (mode),
    .f    (f),
    .rise (rise),
    .fall (fall)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  int rise_cnt[N];
  int fall_cnt[N];
  int overlap_cnt = 0;

  typedef struct {
    logic         rst;
    logic         mode;
    logic [N-1:0] x;
    logic [N-1:0] exp_f;
    logic [N-1:0] exp_rise;
    logic [N-1:0] exp_fall;
  } vec_t;

  vec_t vecs[64];
  int   n_vec = 0;

  task automatic add_vec(input logic r, input logic m, input logic [N-1:0] xv,
                         input logic [N-1:0] ef, input logic [N-1:0] er,
                         input logic [N-1:0] efl);
    vecs[n_vec].rst      = r;
    vecs[n_vec].mode     = m;
    vecs[n_vec].x        = xv;
    vecs[n_vec].exp_f    = ef;
    vecs[n_vec].exp_rise = er;
    vecs[n_vec].exp_fall = efl;
    n_vec++;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // One clock: outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (rise[i]) rise_cnt[i]++;
      if (fall[i]) fall_cnt[i]++;
    end
    if ((rise & fall) != '0) overlap_cnt++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_counts();
    for (int i = 0; i < N; i++) begin
      rise_cnt[i] = 0;
      fall_cnt[i] = 0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ticks(2);
    rst = 1'b0;
    clear_counts();
  endtask

  // ---------------- test ----------------
  logic f1_seen_high;

  initial begin
    rst  = 1'b1;
    x    = '0;
    mode = 1'b0;
    clear_counts();

    // Table: reset, idle, a clean press on x[1] with a mode flip, release.
    add_vec(1, 0, 4'b0000, 4'b0101, 4'b0000, 4'b0000);
    add_vec(1, 0, 4'b0000, 4'b0101, 4'b0000, 4'b0000);
    for (int i = 0; i < 20; i++) add_vec(0, 0, 4'b0000, 4'b0101, 4'b0000, 4'b0000);
    for (int i = 0; i < 5; i++) add_vec(0, 0, 4'b0010, 4'b0101, 4'b0000, 4'b0000);
    add_vec(0, 0, 4'b0010, 4'b0111, 4'b0010, 4'b0000);
    add_vec(0, 0, 4'b0010, 4'b0111, 4'b0000, 4'b0000);
    add_vec(0, 1, 4'b0010, 4'b0010, 4'b0000, 4'b0000);
    add_vec(0, 0, 4'b0010, 4'b0111, 4'b0000, 4'b0000);
    for (int i = 0; i < 5; i++) add_vec(0, 0, 4'b0000, 4'b0111, 4'b0000, 4'b0000);
    add_vec(0, 0, 4'b0000, 4'b0101, 4'b0000, 4'b0010);
    add_vec(0, 0, 4'b0000, 4'b0101, 4'b0000, 4'b0000);

    for (int i = 0; i < n_vec; i++) begin
      rst  = vecs[i].rst;
      mode = vecs[i].mode;
      x    = vecs[i].x;
      tick();
      check($sformatf("vec%0d_f", i),    32'(f),    32'(vecs[i].exp_f));
      check($sformatf("vec%0d_rise", i), 32'(rise), 32'(vecs[i].exp_rise));
      check($sformatf("vec%0d_fall", i), 32'(fall), 32'(vecs[i].exp_fall));
    end

    // Bounce: 3-cycle pulse on x[1] is rejected.
    do_reset();
    x = 4'b0010;
    ticks(3);
    x = 4'b0000;
    ticks(10);
    check("bounce3_f", 32'(f), 32'(4'b0101));
    check("bounce3_rise1", 32'(rise_cnt[1]), 32'd0);
    check("bounce3_fall1", 32'(fall_cnt[1]), 32'd0);

    // 4-cycle pulse is just long enough to be accepted, then released.
    clear_counts();
    f1_seen_high = 1'b0;
    x = 4'b0010;
    for (int i = 0; i < 4; i++) begin tick(); if (f[1]) f1_seen_high = 1'b1; end
    x = 4'b0000;
    for (int i = 0; i < 12; i++) begin tick(); if (f[1]) f1_seen_high = 1'b1; end
    check("bounce4_seen_high", 32'(f1_seen_high), 32'd1);
    check("bounce4_f_end", 32'(f), 32'(4'b0101));
    check("bounce4_rise1", 32'(rise_cnt[1]), 32'd1);
    check("bounce4_fall1", 32'(fall_cnt[1]), 32'd1);

    // Toggle mode: two presses on x[3].
    mode = 1'b1;
    do_reset();
    check("toggle_reset_f", 32'(f), 32'(4'b0000));
    x = 4'b1000; ticks(8);
    check("toggle_press1_f", 32'(f), 32'(4'b1000));
    x = 4'b0000; ticks(8);
    check("toggle_release1_f", 32'(f), 32'(4'b1000));
    x = 4'b1000; ticks(8);
    check("toggle_press2_f", 32'(f), 32'(4'b0000));
    x = 4'b0000; ticks(8);
    check("toggle_release2_f", 32'(f), 32'(4'b0000));
    check("toggle_rise3", 32'(rise_cnt[3]), 32'd2);
    check("toggle_fall3", 32'(fall_cnt[3]), 32'd2);
    mode = 1'b0;
    #1;
    check("toggle_d_end", 32'(f), 32'(4'b0101));

    // Reset in the middle of a debounce on x[2] (cnt reaches 2 after 4 ticks).
    do_reset();
    x = 4'b0100;
    ticks(4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_f", 32'(f), 32'(4'b0101));
    clear_counts();
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("midrst_wait%0d_f", i), 32'(f), 32'(4'b0101));
    end
    check("midrst_no_pulse", 32'(fall_cnt[2] + rise_cnt[2]), 32'd0);
    tick();
    check("midrst_update_f", 32'(f), 32'(4'b0001));
    check("midrst_update_fall", 32'(fall), 32'(4'b0100));

    // All channels change on the same edge.
    do_reset();
    x = 4'b1111;
    ticks(5);
    check("all_pre_f", 32'(f), 32'(4'b0101));
    tick();
    check("all_f", 32'(f), 32'(4'b1010));
    check("all_rise", 32'(rise), 32'(4'b1010));
    check("all_fall", 32'(fall), 32'(4'b0101));
    tick();
    check("all_rise_end", 32'(rise), 32'(4'b0000));
    check("all_fall_end", 32'(fall), 32'(4'b0000));

    check("rise_fall_overlap", 32'(overlap_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/switch_conditioner.md
SWITCH_CONDITIONER -- requirements
Module: switch_conditioner

Interface
REQ-001 Parameter N, default 4: number of independent switch channels, N >= 1.
REQ-002 Parameter DEBOUNCE_CYCLES, default 4: consecutive cycles an input must differ before it is accepted, >= 1.
REQ-003 Parameter INVERT_MASK, default {N{1'b1}}: per-channel polarity; bit i = 1 means channel i is inverted (f = ~x), as the single-gate inverter does.
REQ-004 clk  input  1  sole clock; all registers update on the rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 x  input  N  raw, asynchronous, bouncing switch levels.
REQ-007 mode  input  1  0 = level mode, 1 = toggle mode, shared by all channels, sampled every cycle.
REQ-008 f  output  N  conditioned output per channel.
REQ-009 rise  output  N  one-cycle pulse when a channel's debounced level d goes 0->1.
REQ-010 fall  output  N  one-cycle pulse when a channel's debounced level d goes 1->0.

Function
REQ-011 Each x[i] SHALL pass through a two-flop synchroniser; s[i] is the second flop.
REQ-012 Polarity SHALL be applied after synchronisation: p[i] = s[i] ^ INVERT_MASK[i].
REQ-013 Each channel SHALL hold a debounced level d[i] and a counter cnt[i] of width clog2(DEBOUNCE_CYCLES+1).
REQ-014 Per edge: if p == d, cnt <= 0; if p != d and cnt == DEBOUNCE_CYCLES-1, d <= p and cnt <= 0 (the update edge); otherwise cnt <= cnt+1.
REQ-015 cnt SHALL never exceed DEBOUNCE_CYCLES-1. It has no wrap-around path.
REQ-016 A p mismatch shorter than DEBOUNCE_CYCLES cycles SHALL leave d unchanged and SHALL produce no pulse.
REQ-017 Latency: if x[i] changes before edge k and then stays stable, d[i] updates at edge k+DEBOUNCE_CYCLES+1.
REQ-018 rise[i] and fall[i] SHALL be registered and high for exactly the one cycle following the update edge. rise and fall are never high together on one channel.
REQ-019 Toggle state t[i] SHALL invert on every cycle in which rise[i] is high, in either mode.
REQ-020 f[i] SHALL be d[i] when mode = 0 and t[i] when mode = 1.
REQ-021 f SHALL be a multiplexer of registered values only, so it is glitch-free.
REQ-022 A mode change SHALL take effect on f in the same cycle. It SHALL NOT alter d, t or cnt.
REQ-023 Channels SHALL be fully independent. Simultaneous events on several channels SHALL each be handled per REQ-014 to REQ-019.

Reset
REQ-024 While rst = 1 at an edge, the module SHALL load:
- synchroniser flops <= 0
- cnt <= 0
- d <= INVERT_MASK
- t <= 0
- rise <= 0, fall <= 0
REQ-025 After reset, f SHALL be INVERT_MASK in level mode and 0 in toggle mode.
REQ-026 With x = 0 held through and after reset, no rise or fall pulse SHALL occur.
REQ-027 rst SHALL override every other event in the same cycle, including an update edge. A debounce in progress is discarded.

Structure
REQ-028 A shared constants header SHALL hold the mode encodings (MODE_LEVEL = 0, MODE_TOGGLE = 1) and the default parameter values.
REQ-029 One sub-module, switch_debounce_ch, SHALL implement a single channel (synchroniser, counter, d, t, pulses). The top generates N instances of it.
REQ-030 The RTL SHALL be synthesisable and SHALL use no switch-level primitives.

Verification
All scenarios use N = 4, DEBOUNCE_CYCLES = 4, INVERT_MASK = 4'b0101.
REQ-031 rst for 2 cycles with x = 0, mode = 0, then 20 idle cycles -> f = 4'b0101, rise = fall = 0 throughout.
REQ-032 x[1] 0->1 before edge k, then held -> f[1] = 1 after edge k+5; rise[1] high for exactly one cycle; other channels unchanged.
REQ-033 Bounce test on x[1]:
- a 3-cycle high pulse -> no change on f[1] and no pulse
- a 4-cycle high pulse -> f[1] rises, then falls after the return; one rise and one fall pulse
REQ-034 mode = 1, two presses on x[3] (8 cycles high, 8 cycles low each) -> f[3] goes 0->1 then 1->0; two rise[3] and two fall[3] pulses; d[3] ends at 0.
REQ-035 rst asserted while cnt[2] = 2 during an x[2] change -> after release f = 4'b0101 with no pulse; a fresh DEBOUNCE_CYCLES+2 latency applies from the release.
REQ-036 x = 4'b1111 applied on one edge -> f = 4'b1010 after 6 cycles; rise = 4'b1010 and fall = 4'b0101 for the same single cycle.
